// File: rtl/i2s_apb_scheduler_if.sv
`default_nettype none
// =============================================================================
// i2s_apb_scheduler_if
// Stream, APB master and status signals of the I2S APB scheduler.
// Revision: 1.0
// =============================================================================
interface i2s_apb_scheduler_if;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        tx_full;
  logic        rx_ready;
  logic        rx_empty;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        busy;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        err;

  // Scheduler side
  modport master (
    input  cfg_valid, cfg_data, tx_valid, tx_data, tx_full, rx_ready, rx_empty,
    input  prdata, pready,
    output cfg_ready, tx_ready, rx_valid, rx_data,
    output psel, penable, pwrite, paddr, pwdata,
    output busy, tx_count, rx_count, err
  );

  // Stream sources / APB slave side
  modport slave (
    output cfg_valid, cfg_data, tx_valid, tx_data, tx_full, rx_ready, rx_empty,
    output prdata, pready,
    input  cfg_ready, tx_ready, rx_valid, rx_data,
    input  psel, penable, pwrite, paddr, pwdata,
    input  busy, tx_count, rx_count, err
  );
endinterface
`default_nettype wire

// File: rtl/i2s_apb_scheduler.sv
`default_nettype none
// =============================================================================
// i2s_apb_scheduler
// APB master arbitrating config writes, TX samples and RX reads into one I2S_top.
// Optional: define I2S_SCHED_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles.
// Revision: 1.0
// =============================================================================
module i2s_apb_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] CTRL_OFS  = 32'h0,
  parameter logic [31:0] TXD_OFS   = 32'h4,
  parameter logic [31:0] RXD_OFS   = 32'h8,
  parameter int unsigned TIMEOUT   = 16
) (
  input wire                  pclk,
  input wire                  preset,
  i2s_apb_scheduler_if.master bus
);

`ifdef I2S_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_CFG = 2'd0,
    REQ_TX  = 2'd1,
    REQ_RX  = 2'd2
  } req_t;

  state_t          state_q, state_d;
  req_t            kind_q, kind_d;
  logic            last_rx_q, last_rx_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic [15:0]     tx_count_q, tx_count_d;
  logic [15:0]     rx_count_q, rx_count_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  logic elig_tx, elig_rx;
  logic cfg_grant, tx_grant, rx_grant;
  logic timeout_hit;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    last_rx_d  = last_rx_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    to_cnt_d   = '0;
    err_d      = 1'b0;
    cfg_grant  = 1'b0;
    tx_grant   = 1'b0;
    rx_grant   = 1'b0;

    elig_tx     = bus.tx_valid & ~bus.tx_full;
    elig_rx     = bus.rx_ready & ~bus.rx_empty;
    timeout_hit = TIMEOUT_EN & ~bus.pready & (to_cnt_q == TO_W'(TIMEOUT - 1));

    unique case (state_q)
      ST_IDLE: begin
        // Config wins outright; TX and RX alternate when both are eligible.
        if (bus.cfg_valid)           cfg_grant = 1'b1;
        else if (elig_tx && elig_rx) begin
          tx_grant = last_rx_q;
          rx_grant = ~last_rx_q;
        end
        else if (elig_tx)            tx_grant = 1'b1;
        else if (elig_rx)            rx_grant = 1'b1;

        if (cfg_grant) begin
          kind_d   = REQ_CFG;
          paddr_d  = BASE_ADDR + CTRL_OFS;
          pwdata_d = bus.cfg_data;
          pwrite_d = 1'b1;
          state_d  = ST_SETUP;
        end else if (tx_grant) begin
          kind_d    = REQ_TX;
          paddr_d   = BASE_ADDR + TXD_OFS;
          pwdata_d  = bus.tx_data;
          pwrite_d  = 1'b1;
          last_rx_d = 1'b0;
          state_d   = ST_SETUP;
        end else if (rx_grant) begin
          kind_d    = REQ_RX;
          paddr_d   = BASE_ADDR + RXD_OFS;
          pwrite_d  = 1'b0;
          last_rx_d = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          state_d = ST_IDLE;
          if (kind_q == REQ_TX) tx_count_d = tx_count_q + 16'd1;
          if (kind_q == REQ_RX) begin
            rx_count_d = rx_count_q + 16'd1;
            rx_data_d  = bus.prdata;
            rx_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          // Abandoned transfer: nothing counted, nothing delivered.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      kind_q     <= REQ_CFG;
      last_rx_q  <= 1'b1;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      last_rx_q  <= last_rx_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.cfg_ready = cfg_grant;
  assign bus.tx_ready  = tx_grant;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.psel      = (state_q != ST_IDLE);
  assign bus.penable   = (state_q == ST_ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.tx_count  = tx_count_q;
  assign bus.rx_count  = rx_count_q;
  assign bus.err       = TIMEOUT_EN ? err_q : 1'b0;

endmodule
`default_nettype wire
